frv_ccx_unit: RTL and testbench

Custom compute extension (CCX) accelerator for the FazyRV core. It sits directly downstream of the core's chunk-serial CCX port. It deserializes two 32-bit operands streamed in CHUNKSIZE-bit chunks, executes one of four selectable operations, and streams the 32-bit result back in chunks. It is instanced next to the core in the 4ccx macro, with its outputs tied to the core's `ccx_res_i`/`ccx_resp_i`.

---
 rtl/frv_ccx_pkg.sv | 32 +++
 rtl/frv_ccx_mul.sv | 48 ++++
 rtl/frv_ccx_unit.sv | 142 ++++++++++++++
 tb/tb_frv_ccx_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/frv_ccx_pkg.sv
// Shared types and helpers for the FazyRV CCX accelerator.
// Build option: FRV_CCX_MUL_EN enables the iterative MULL path.
package frv_ccx_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OP_REV8 = 2'd0,
    OP_CPOP = 2'd1,
    OP_MINU = 2'd2,
    OP_MULL = 2'd3
  } ccx_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } ccx_state_e;

  function automatic logic [XLEN-1:0] rev8(input logic [XLEN-1:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [XLEN-1:0] popcount(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] n;
    n = '0;
    for (int i = 0; i < XLEN; i++) n = n + XLEN'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/frv_ccx_mul.sv
// Iterative multiplier: one CHUNKSIZE-bit slice of b per cycle, low 32 bits kept.
// done is high in the cycle of the final accumulation; prod carries that final sum.
module frv_ccx_mul
  import frv_ccx_pkg::*;
#(
  parameter int CHUNKSIZE = 4
) (
  input  logic            clk_i,
  input  logic            rst_in,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] prod
);

  localparam int NBEATS = XLEN / CHUNKSIZE;
  localparam logic [4:0] LAST = 5'(NBEATS - 1);
  localparam logic [XLEN-1:0] MASK = XLEN'((64'd1 << CHUNKSIZE) - 64'd1);

  logic [4:0]      k_q;
  logic [XLEN-1:0] acc_q;
  logic            run;
  logic [4:0]      shamt;
  logic [XLEN-1:0] chunk;
  logic [XLEN-1:0] sum;

  // k_q is nonzero only while an iteration sequence is in flight
  always_comb begin
    run   = start || (k_q != '0);
    shamt = 5'(k_q * 5'(CHUNKSIZE));
    chunk = (b >> shamt) & MASK;
    sum   = (start ? '0 : acc_q) + ((a * chunk) << shamt);
    done  = run && (k_q == LAST);
    prod  = sum;
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      k_q   <= '0;
      acc_q <= '0;
    end else if (run) begin
      acc_q <= sum;
      k_q   <= done ? '0 : k_q + 5'd1;
    end
  end

endmodule

// File: rtl/frv_ccx_unit.sv
// CCX accelerator: deserializes two operands, runs REV8/CPOP/MINU/MULL, streams result.
// Build option: FRV_CCX_MUL_EN (undefined: sel=3 returns 0 with single-cycle timing).
//
// state | meaning
// IDLE  | waiting for req; captures beat 0 and sel
// LOAD  | collecting operand beats 1..NBEATS-1; req low aborts
// EXEC  | computing result (1 cycle, or NBEATS cycles for MULL)
// RESP  | streaming result chunks, LSB first
module frv_ccx_unit
  import frv_ccx_pkg::*;
#(
  parameter int CHUNKSIZE = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_in,
  input  logic                 ccx_req_i,
  input  logic [1:0]           ccx_sel_i,
  input  logic [CHUNKSIZE-1:0] ccx_rs_a_i,
  input  logic [CHUNKSIZE-1:0] ccx_rs_b_i,
  output logic [CHUNKSIZE-1:0] ccx_res_o,
  output logic                 ccx_resp_o,
  output logic                 busy_o
);

  localparam int NBEATS = XLEN / CHUNKSIZE;
  localparam logic [4:0] LAST = 5'(NBEATS - 1);

  ccx_state_e      state_q, state_d;
  ccx_op_e         op_q;
  logic [XLEN-1:0] a_q, b_q, res_q;
  logic [4:0]      cnt_q;
  logic [4:0]      shamt;
  logic [XLEN-1:0] exec_res;
  logic            exec_done;

`ifdef FRV_CCX_MUL_EN
  logic            mul_start;
  logic            mul_done;
  logic [XLEN-1:0] mul_prod;

  assign mul_start = (state_q == ST_EXEC) && (op_q == OP_MULL) && (cnt_q == '0);

  frv_ccx_mul #(
    .CHUNKSIZE(CHUNKSIZE)
  ) u_mul (
    .clk_i (clk_i),
    .rst_in(rst_in),
    .start (mul_start),
    .a     (a_q),
    .b     (b_q),
    .done  (mul_done),
    .prod  (mul_prod)
  );
`endif

  always_comb begin
    shamt    = 5'(cnt_q * 5'(CHUNKSIZE));
    exec_res = '0;
    case (op_q)
      OP_REV8: exec_res = rev8(a_q);
      OP_CPOP: exec_res = popcount(a_q);
      OP_MINU: exec_res = (a_q < b_q) ? a_q : b_q;
`ifdef FRV_CCX_MUL_EN
      OP_MULL: exec_res = mul_prod;
`endif
      default: exec_res = '0;
    endcase
`ifdef FRV_CCX_MUL_EN
    exec_done = (op_q != OP_MULL) || mul_done;
`else
    exec_done = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ccx_req_i) state_d = (NBEATS == 1) ? ST_EXEC : ST_LOAD;
      ST_LOAD: begin
        if (!ccx_req_i)          state_d = ST_IDLE;
        else if (cnt_q == LAST) state_d = ST_EXEC;
      end
      ST_EXEC: if (exec_done) state_d = ST_RESP;
      ST_RESP: if (cnt_q == LAST) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      op_q  <= OP_REV8;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (ccx_req_i) begin
          op_q  <= ccx_op_e'(ccx_sel_i);
          a_q   <= XLEN'(ccx_rs_a_i);
          b_q   <= XLEN'(ccx_rs_b_i);
          cnt_q <= (NBEATS == 1) ? 5'd0 : 5'd1;
        end
        ST_LOAD: begin
          if (!ccx_req_i) begin
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
          end else begin
            a_q   <= a_q | (XLEN'(ccx_rs_a_i) << shamt);
            b_q   <= b_q | (XLEN'(ccx_rs_b_i) << shamt);
            cnt_q <= (cnt_q == LAST) ? 5'd0 : cnt_q + 5'd1;
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            res_q <= exec_res;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        ST_RESP: begin
          // Shifting out leaves res_q at zero once the last chunk is sent
          res_q <= res_q >> CHUNKSIZE;
          cnt_q <= (cnt_q == LAST) ? 5'd0 : cnt_q + 5'd1;
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign ccx_resp_o = (state_q == ST_RESP);
  assign ccx_res_o  = ccx_resp_o ? res_q[CHUNKSIZE-1:0] : '0;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_frv_ccx_unit.sv
// Directed bench for frv_ccx_unit at CHUNKSIZE=4; MULL expectations follow FRV_CCX_MUL_EN.
`timescale 1ns/1ps
module tb_frv_ccx_unit;

  localparam int CS = 4;
  localparam int NB = 32 / CS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic [1:0]    sel = 2'd0;
  logic [CS-1:0] rs_a = '0;
  logic [CS-1:0] rs_b = '0;
  logic [CS-1:0] res;
  logic          resp;
  logic          busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  frv_ccx_unit #(.CHUNKSIZE(CS)) dut (
    .clk_i     (clk),
    .rst_in    (rst_n),
    .ccx_req_i (req),
    .ccx_sel_i (sel),
    .ccx_rs_a_i(rs_a),
    .ccx_rs_b_i(rs_b),
    .ccx_res_o (res),
    .ccx_resp_o(resp),
    .busy_o    (busy)
  );

  // Called just after a posedge. Beat k is captured at edge k; cycle t_c is the
  // interval sampled by edge c. Returns just after the edge that closes the last
  // resp cycle (full run), or at the negedge of the stop_at-th resp beat.
  task automatic run_txn(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b,
                         input int stop_at, output logic [31:0] r, output int first,
                         output int nres, output logic stray);
    r = '0; first = -1; nres = 0; stray = 1'b0;
    for (int k = 0; k < NB; k++) begin
      #1;
      req  = 1'b1;
      sel  = (k == 0) ? s : ~s;
      rs_a = a[k*CS +: CS];
      rs_b = b[k*CS +: CS];
      @(posedge clk);
    end
    #1;
    req = 1'b0; rs_a = '0; rs_b = '0;
    for (int c = NB; c < NB*3 + 4; c++) begin
      @(negedge clk);
      if (resp) begin
        if (first < 0) first = c;
        r[nres*CS +: CS] = res;
        nres++;
      end else if (res !== '0) begin
        stray = 1'b1;
      end
      if (nres == stop_at) break;
      @(posedge clk);
    end
    if (nres == stop_at && stop_at == NB) @(posedge clk);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({resp, busy, res} !== '0) $display("FAIL reset_outputs: got resp=%b busy=%b res=%h expected all 0", resp, busy, res);
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_rev8();
    logic [31:0] r; int first, nres; logic stray;
    run_txn(2'd0, 32'h1234_5678, 32'h0, NB, r, first, nres, stray);
    chk32("rev8_result", r, 32'h7856_3412);
    chk32("rev8_first_resp", 32'(first), 32'd9);
    chk32("rev8_res_zero_when_idle", 32'(stray), 32'd0);
    @(negedge clk);
    total_cnt++;
    if (resp !== 1'b0 || busy !== 1'b0) $display("FAIL rev8_resp_len: got resp=%b busy=%b after 8 beats expected 0 0", resp, busy);
    else pass_cnt++;
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int first, nres; logic stray;
    run_txn(2'd2, 32'h0000_0005, 32'hFFFF_FFFF, NB, r, first, nres, stray);
    chk32("minu_result", r, 32'h0000_0005);
    chk32("minu_first_resp", 32'(first), 32'd9);
    run_txn(2'd1, 32'hF0F0_0001, 32'h1234_5678, NB, r, first, nres, stray);
    chk32("cpop_b2b_result", r, 32'h0000_0009);
    chk32("cpop_b2b_first_resp", 32'(first), 32'd9);
  endtask

  task automatic test_mull();
    logic [31:0] r; int first, nres; logic stray;
`ifdef FRV_CCX_MUL_EN
    run_txn(2'd3, 32'h0001_0003, 32'h0000_0010, NB, r, first, nres, stray);
    chk32("mull_small_result", r, 32'h0010_0030);
    chk32("mull_small_first_resp", 32'(first), 32'd16);
    chk32("mull_res_zero_when_idle", 32'(stray), 32'd0);
    run_txn(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NB, r, first, nres, stray);
    chk32("mull_wrap_result", r, 32'h0000_0001);
    chk32("mull_wrap_first_resp", 32'(first), 32'd16);
`else
    run_txn(2'd3, 32'h0001_0003, 32'h0000_0010, NB, r, first, nres, stray);
    chk32("mull_off_result", r, 32'h0000_0000);
    chk32("mull_off_first_resp", 32'(first), 32'd9);
`endif
  endtask

  task automatic test_abort();
    logic [31:0] r; int first, nres; logic stray;
    logic saw_resp;
    logic [31:0] a;
    a = 32'h9876_5432;
    for (int k = 0; k < 3; k++) begin
      #1;
      req = 1'b1; sel = 2'd0; rs_a = a[k*CS +: CS]; rs_b = '0;
      if (k == 0) begin
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL busy_before_t0: got %b expected 0", busy);
        else pass_cnt++;
      end
      @(posedge clk);
      if (k == 0) begin
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL busy_after_t0: got %b expected 1", busy);
        else pass_cnt++;
      end
    end
    #1;
    req = 1'b0; rs_a = '0;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy);
    else pass_cnt++;
    saw_resp = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (resp !== 1'b0 || res !== '0) saw_resp = 1'b1;
    end
    chk32("abort_no_resp", 32'(saw_resp), 32'd0);
    @(posedge clk);
    run_txn(2'd0, 32'hAABB_CCDD, 32'h0, NB, r, first, nres, stray);
    chk32("rev8_after_abort", r, 32'hDDCC_BBAA);
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int first, nres; logic stray;
    run_txn(2'd0, 32'h1234_5678, 32'h0, 4, r, first, nres, stray);
    chk32("mid_reset_reached_beat4", 32'(nres), 32'd4);
    #1;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({resp, busy, res} !== '0) $display("FAIL mid_reset_outputs: got resp=%b busy=%b res=%h expected all 0", resp, busy, res);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    run_txn(2'd1, 32'hFFFF_FFFF, 32'h0, NB, r, first, nres, stray);
    chk32("cpop_after_reset", r, 32'h0000_0020);
    chk32("cpop_after_reset_first", 32'(first), 32'd9);
  endtask

  initial begin
    test_reset();
    test_rev8();
    test_back_to_back();
    test_mull();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
